// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM state
// codes and the datapath mux-select encodings.
package mips_ctrl_pkg;

  // Opcodes (IR[31:26]) understood by the controller
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // State codes; these values are visible on the debug port
  localparam logic [3:0] ST_FETCH   = 4'd0;
  localparam logic [3:0] ST_DECODE  = 4'd1;
  localparam logic [3:0] ST_MEMADR  = 4'd2;
  localparam logic [3:0] ST_MEMRD   = 4'd3;
  localparam logic [3:0] ST_MEMWB   = 4'd4;
  localparam logic [3:0] ST_MEMWR   = 4'd5;
  localparam logic [3:0] ST_RTYPEEX = 4'd6;
  localparam logic [3:0] ST_RTYPEWB = 4'd7;
  localparam logic [3:0] ST_BEQEX   = 4'd8;
  localparam logic [3:0] ST_ADDIEX  = 4'd9;
  localparam logic [3:0] ST_ADDIWB  = 4'd10;
  localparam logic [3:0] ST_JEX     = 4'd11;

  typedef enum logic [3:0] {
    StFetch   = ST_FETCH,
    StDecode  = ST_DECODE,
    StMemAdr  = ST_MEMADR,
    StMemRd   = ST_MEMRD,
    StMemWb   = ST_MEMWB,
    StMemWr   = ST_MEMWR,
    StRtypeEx = ST_RTYPEEX,
    StRtypeWb = ST_RTYPEWB,
    StBeqEx   = ST_BEQEX,
    StAddiEx  = ST_ADDIEX,
    StAddiWb  = ST_ADDIWB,
    StJEx     = ST_JEX
  } state_t;

  // ALU operation select
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B operand select
  localparam logic [1:0] ALUSRCB_B      = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
  localparam logic [1:0] ALUSRCB_BRANCH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_out_decode.sv
// Combinational output decode: maps the current FSM state (plus mem_ready for
// the fetch handshake) onto every datapath select and write enable.
module mc_out_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc
);

  // Per-state control decode; anything not set for a state stays 0
  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = ALUSRCB_B;
    aluop       = ALUOP_ADD;
    pcsrc       = PCSRC_ALU;
    case (state)
      StFetch: begin
        memread = 1'b1;
        alusrcb = ALUSRCB_FOUR;
        // IR and PC only latch once memory actually returns the word
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      StDecode: begin
        alusrcb = ALUSRCB_BRANCH;
      end
      StMemAdr, StAddiEx: begin
        alusrca = 1'b1;
        alusrcb = ALUSRCB_IMM;
      end
      StMemRd: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      StMemWr: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      StMemWb: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      StRtypeEx: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      StRtypeWb: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      StBeqEx: begin
        alusrca     = 1'b1;
        aluop       = ALUOP_SUB;
        pcsrc       = PCSRC_ALUOUT;
        pcwritecond = 1'b1;
      end
      StAddiWb: begin
        regwrite = 1'b1;
      end
      StJEx: begin
        pcwrite = 1'b1;
        pcsrc   = PCSRC_JUMP;
      end
      default: begin
        // unreachable codes drive nothing
      end
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath, with a memory-wait
// timeout that forces a refetch if memory never answers.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic [3:0] state,
  output logic       illegal_op,
  output logic       mem_err
);

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q;
  logic                in_wait;
  logic                timeout;

  // Next-state selection, illegal-opcode flag and memory-wait timeout
  always_comb begin
    state_d    = state_q;
    in_wait    = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      StFetch: begin
        in_wait = 1'b1;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        case (op)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_RTYPE:     state_d = StRtypeEx;
          OP_BEQ:       state_d = StBeqEx;
          OP_ADDI:      state_d = StAddiEx;
          OP_J:         state_d = StJEx;
          default: begin
            state_d    = StFetch;
            illegal_op = 1'b1;
          end
        endcase
      end
      // IR is stable after fetch, so op can be re-examined here unlatched
      StMemAdr:  state_d = (op == OP_LW) ? StMemRd : StMemWr;
      StMemRd: begin
        in_wait = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWr: begin
        in_wait = 1'b1;
        if (mem_ready) state_d = StFetch;
      end
      StRtypeEx: state_d = StRtypeWb;
      StAddiEx:  state_d = StAddiWb;
      StMemWb, StRtypeWb, StAddiWb, StBeqEx, StJEx: state_d = StFetch;
      default:   state_d = StFetch;
    endcase
    // A late mem_ready in the final wait cycle still wins over the timeout
    timeout = in_wait && !mem_ready && (wait_q == '1);
    if (timeout) state_d = StFetch;
  end

  // State register and saturating wait counter, cleared on any state change
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      if (timeout || (state_d != state_q)) begin
        wait_q <= '0;
      end else if (in_wait && !mem_ready && (wait_q != '1)) begin
        wait_q <= wait_q + WAIT_W'(1);
      end
    end
  end

  assign mem_err = timeout;
  assign state   = state_q;

  mc_out_decode u_out_decode (
    .state       (state_q),
    .mem_ready   (mem_ready),
    .pcwrite     (pcwrite),
    .pcwritecond (pcwritecond),
    .iord        (iord),
    .memread     (memread),
    .memwrite    (memwrite),
    .irwrite     (irwrite),
    .memtoreg    (memtoreg),
    .regdst      (regdst),
    .regwrite    (regwrite),
    .alusrca     (alusrca),
    .alusrcb     (alusrcb),
    .aluop       (aluop),
    .pcsrc       (pcsrc)
  );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed scenarios followed by randomized
// opcodes, memory stalls and resets, checked against an instruction-path model.
module tb_mips_multicycle_ctrl;

  localparam int WAIT_W = 4;
  localparam int LIMIT  = (1 << WAIT_W) - 1;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       mem_ready;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic [3:0] state;
  logic       illegal_op, mem_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: the state list an instruction walks through, position, wait count
  int mpath[$];
  int mpos  = 0;
  int mwait = 0;

  logic [5:0] legal_ops [6] = '{LW, SW, RT, BEQ, ADDI, JMP};

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.WAIT_W(WAIT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .mem_ready   (mem_ready),
    .pcwrite     (pcwrite),
    .pcwritecond (pcwritecond),
    .iord        (iord),
    .memread     (memread),
    .memwrite    (memwrite),
    .irwrite     (irwrite),
    .memtoreg    (memtoreg),
    .regdst      (regdst),
    .regwrite    (regwrite),
    .alusrca     (alusrca),
    .alusrcb     (alusrcb),
    .aluop       (aluop),
    .pcsrc       (pcsrc),
    .state       (state),
    .illegal_op  (illegal_op),
    .mem_err     (mem_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] o);
    return o inside {LW, SW, RT, BEQ, ADDI, JMP};
  endfunction

  // Control word expected in a given state, straight from the output table
  function automatic logic [17:0] exp_ctrl(input int st, input bit rdy, input bit ill,
                                           input bit err);
    logic       pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa;
    logic [1:0] asb, aop, pcs;
    {pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa} = '0;
    asb = 2'b00;
    aop = 2'b00;
    pcs = 2'b00;
    case (st)
      0:    begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
      1:    begin asb = 2'b11; end
      2, 9: begin asa = 1; asb = 2'b10; end
      3:    begin mr = 1; io = 1; end
      4:    begin rw = 1; m2r = 1; end
      5:    begin mw = 1; io = 1; end
      6:    begin asa = 1; aop = 2'b10; end
      7:    begin rw = 1; rd = 1; end
      8:    begin asa = 1; aop = 2'b01; pcs = 2'b01; pwc = 1; end
      10:   begin rw = 1; end
      11:   begin pw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs, ill, err};
  endfunction

  function automatic int model_state();
    if (mpos == 0) return 0;
    if (mpos == 1) return 1;
    return mpath[mpos];
  endfunction

  // One clock: apply inputs, check outputs mid-cycle, then advance the model
  task automatic run_cycle(input logic [5:0] o, input bit rdy, input bit rst);
    int          cur;
    bit          waiting, err, ill;
    logic [17:0] obs;
    @(posedge clk);
    #1;
    op        = o;
    mem_ready = rdy;
    reset     = rst;
    cur       = model_state();
    waiting   = (cur == 0) || (cur == 3) || (cur == 5);
    err       = waiting && !rdy && (mwait == LIMIT);
    ill       = (cur == 1) && !is_legal(o);
    @(negedge clk);
    obs = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst,
           regwrite, alusrca, alusrcb, aluop, pcsrc, illegal_op, mem_err};
    check_eq("state", 32'(state), 32'(cur));
    check_eq($sformatf("ctrl@st%0d", cur), 32'(obs), 32'(exp_ctrl(cur, rdy, ill, err)));
    if (rst) begin
      mpos  = 0;
      mwait = 0;
    end else if (waiting && !rdy) begin
      if (mwait == LIMIT) begin
        mpos  = 0;
        mwait = 0;
      end else begin
        mwait++;
      end
    end else begin
      mwait = 0;
      if (cur == 1) begin
        case (o)
          LW:      mpath = '{0, 1, 2, 3, 4};
          SW:      mpath = '{0, 1, 2, 5};
          RT:      mpath = '{0, 1, 6, 7};
          BEQ:     mpath = '{0, 1, 8};
          ADDI:    mpath = '{0, 1, 9, 10};
          JMP:     mpath = '{0, 1, 11};
          default: mpath = '{0, 1};
        endcase
      end
      mpos++;
      if (mpos > 1 && mpos >= mpath.size()) mpos = 0;
    end
  endtask

  initial begin
    int          p;
    logic [5:0]  cur_op;
    reset     = 1'b1;
    op        = 6'd0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state with memory idle, then lw with memory always ready
    run_cycle(LW, 1'b0, 1'b0);
    repeat (5) run_cycle(LW, 1'b1, 1'b0);

    // sw stalled three cycles in the write phase
    repeat (3) run_cycle(SW, 1'b1, 1'b0);
    repeat (3) run_cycle(SW, 1'b0, 1'b0);
    run_cycle(SW, 1'b1, 1'b0);

    // beq, j, addi, R-type, then an unsupported opcode
    repeat (3) run_cycle(BEQ, 1'b1, 1'b0);
    repeat (3) run_cycle(JMP, 1'b1, 1'b0);
    repeat (4) run_cycle(ADDI, 1'b1, 1'b0);
    repeat (4) run_cycle(RT, 1'b1, 1'b0);
    repeat (2) run_cycle(6'b111111, 1'b1, 1'b0);

    // Fetch timeout, then mem_ready arriving exactly in the timeout cycle
    repeat (LIMIT + 1) run_cycle(RT, 1'b0, 1'b0);
    repeat (LIMIT) run_cycle(RT, 1'b0, 1'b0);
    repeat (4) run_cycle(RT, 1'b1, 1'b0);

    // Reset while in MEMRD aborts the load
    repeat (3) run_cycle(LW, 1'b1, 1'b0);
    run_cycle(LW, 1'b0, 1'b1);
    run_cycle(LW, 1'b0, 1'b0);
    check_eq("abort_we", 32'({pcwrite, pcwritecond, irwrite, regwrite, memwrite}), 32'd0);

    // Randomized instruction stream with variable memory latency and resets
    p      = 100;
    cur_op = LW;
    for (int i = 0; i < 5000; i++) begin
      if (mpos == 0) begin
        if ($urandom_range(0, 7) < 6) cur_op = legal_ops[$urandom_range(0, 5)];
        else cur_op = 6'($urandom);
        if ($urandom_range(0, 7) == 0) begin
          case ($urandom_range(0, 3))
            0:       p = 100;
            1:       p = 75;
            2:       p = 40;
            default: p = 5;
          endcase
        end
      end
      run_cycle(cur_op, ($urandom_range(0, 99) < p), ($urandom_range(0, 199) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
